// File: rtl/dot_accum_if.sv
// rtl/dot_accum_if.sv - product input stream and result output port of dot_accum
interface dot_accum_if #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*BIT_WIDTH-1:0] in_product;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_sum;
  logic [CNT_WIDTH-1:0]   out_count;
  logic                   out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/dot_accum.sv
// rtl/dot_accum.sv - saturating per-vector sum of multiplier products with a registered result port
module dot_accum #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  dot_accum_if.slave  bus
);
  localparam int PW = 2 * BIT_WIDTH;

  typedef enum logic {EMPTY, PARTIAL} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;
  logic [ACC_WIDTH-1:0] out_sum_q;
  logic [CNT_WIDTH-1:0] out_cnt_q;
  logic                 out_ovf_q;
  logic                 out_valid_q;

  logic                 in_ready;
  logic                 accept;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ovf_d;

  // Stall every beat while an unconsumed result sits in the output register.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !flush;

  always_comb begin
    sum_wide = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PW){1'b0}}, bus.in_product};
    acc_d    = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
    ovf_d    = ovf_q | sum_wide[ACC_WIDTH];
    if (state_q == EMPTY) begin
      cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Reset is active-high even though the port is called rst_n.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (flush) begin
        state_q <= EMPTY;
        acc_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (accept) begin
        if (bus.in_last) begin
          state_q   <= EMPTY;
          acc_q     <= '0;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
          out_sum_q <= acc_d;
          out_cnt_q <= cnt_d;
          out_ovf_q <= ovf_d;
        end else begin
          state_q <= PARTIAL;
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
        end
      end

      if (accept && bus.in_last) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_dot_accum.sv
// tb/tb_dot_accum.sv - directed and randomised checks of dot_accum with a 16-bit accumulator and 2-bit counter
module tb_dot_accum;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dot_accum_if #(.BIT_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(2)) bus ();

  dot_accum #(.BIT_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] p, input logic l);
    bus.in_valid   = v;
    bus.in_product = p;
    bus.in_last    = l;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] s, input logic [1:0] c, input logic o);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_sum"},   {16'd0, bus.out_sum},   {16'd0, s});
    check({tag, "_count"}, {30'd0, bus.out_count}, {30'd0, c});
    check({tag, "_ovf"},   {31'd0, bus.out_ovf},   {31'd0, o});
  endtask

  int m_acc, m_cnt, m_ovf, m_sum, m_count, m_ovfo, m_ov;
  int s, c, o;
  logic v, l, r, f, ok;
  logic [15:0] p;

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0);
    #1;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_sum",   {16'd0, bus.out_sum},   32'd0);
    check("rst_out_count", {30'd0, bus.out_count}, 32'd0);
    step(); step();
    rst_n = 1'b0;

    // streaming {1,2,3} then {10}
    drive(1, 1, 0); step();
    drive(1, 2, 0); step();
    check("stream_no_early", {31'd0, bus.out_valid}, 32'd0);
    drive(1, 3, 1); step();
    chk_out("stream_a", 16'd6, 2'd3, 1'b0);
    drive(1, 10, 1); step();
    chk_out("stream_b", 16'd10, 2'd1, 1'b0);
    drive(0, 0, 0); step();
    check("stream_drain", {31'd0, bus.out_valid}, 32'd0);

    // five terms saturate the 2-bit count at 3
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0); step();
    end
    drive(1, 1, 1); step();
    chk_out("cnt_sat", 16'd5, 2'd3, 1'b0);

    // backpressure
    drive(1, 2, 0); step();
    drive(1, 4, 1); bus.out_ready = 1'b0; step();
    chk_out("bp_res", 16'd6, 2'd2, 1'b0);
    drive(1, 100, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    chk_out("bp_hold", 16'd6, 2'd2, 1'b0);
    drive(1, 5, 1); bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk_out("bp_next", 16'd5, 2'd1, 1'b0);
    drive(0, 0, 0); step();
    check("bp_drain", {31'd0, bus.out_valid}, 32'd0);

    // saturation
    drive(1, 16'hFF00, 0); step();
    drive(1, 16'h0200, 0); step();
    drive(1, 16'h0001, 1); step();
    chk_out("sat", 16'hFFFF, 2'd3, 1'b1);
    drive(1, 5, 1); step();
    chk_out("sat_next", 16'd5, 2'd1, 1'b0);

    // flush
    drive(1, 7, 0); step();
    drive(1, 8, 0); step();
    flush = 1'b1; drive(1, 9, 1); step();
    flush = 1'b0;
    check("flush_discard", {31'd0, bus.out_valid}, 32'd0);
    drive(1, 2, 1); step();
    chk_out("flush_next", 16'd2, 2'd1, 1'b0);
    bus.out_ready = 1'b0; flush = 1'b1; drive(1, 9, 1); step();
    chk_out("flush_pending", 16'd2, 2'd1, 1'b0);
    flush = 1'b0; bus.out_ready = 1'b1; drive(0, 0, 0); step();
    check("flush_drain", {31'd0, bus.out_valid}, 32'd0);

    // reset with a pending result, then with a partial vector
    drive(1, 9, 1); step();
    chk_out("pre_rst", 16'd9, 2'd1, 1'b0);
    bus.out_ready = 1'b0; drive(0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_sum",      {16'd0, bus.out_sum},   32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready},  32'd1);
    step();
    rst_n = 1'b0; bus.out_ready = 1'b1;
    drive(1, 6, 0); step();
    rst_n = 1'b1; drive(0, 0, 0); step();
    rst_n = 1'b0;
    drive(1, 3, 0); step();
    drive(1, 4, 1); step();
    chk_out("post_rst", 16'd7, 2'd2, 1'b0);
    drive(0, 0, 0); step();

    // random traffic against a reference model
    m_acc = 0; m_cnt = 0; m_ovf = 0; m_ov = 0;
    m_sum = 0; m_count = 0; m_ovfo = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(30000, 65535)) : 16'($urandom_range(0, 255));
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 15) == 0);
      drive(v, p, l); bus.out_ready = r; flush = f;
      #1;
      check("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, (m_ov == 0) || r});
      ok = v && ((m_ov == 0) || r) && !f;
      if (f) begin
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else if (ok) begin
        s = m_acc + int'(p);
        o = m_ovf;
        if (s > 65535) begin s = 65535; o = 1; end
        c = (m_cnt == 3) ? 3 : m_cnt + 1;
        if (l) begin
          m_sum = s; m_count = c; m_ovfo = o;
          m_acc = 0; m_cnt = 0; m_ovf = 0;
        end else begin
          m_acc = s; m_cnt = c; m_ovf = o;
        end
      end
      if (ok && l) m_ov = 1;
      else if (r) m_ov = 0;
      step();
      check("rnd_valid", {31'd0, bus.out_valid}, m_ov);
      if (m_ov != 0) begin
        check("rnd_sum",   {16'd0, bus.out_sum},   m_sum);
        check("rnd_count", {30'd0, bus.out_count}, m_count);
        check("rnd_ovf",   {31'd0, bus.out_ovf},   m_ovfo);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dot_accum.md
# dot_accum

Streaming dot-product accumulator that sits directly downstream of the pipelined unsigned multiplier. It consumes one `2*BIT_WIDTH`-bit product per cycle, sums the products of one vector (delimited by `in_last`) into a saturating accumulator, and presents the finished sum, term count and overflow flag on a valid/ready output port. Upstream control is responsible for delaying `in_valid`/`in_last` by the multiplier latency (2 cycles) so they align with the product.

## Interface

- `BIT_WIDTH`, default 8: multiplier operand width; product width is `2*BIT_WIDTH`.
- `ACC_WIDTH`, default 32: accumulator and result width; must be ≥ `2*BIT_WIDTH`.
- `CNT_WIDTH`, default 16: term-counter width.

Ports:

- `clk` input 1: clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-high (despite the name).
- `flush` input 1: synchronous discard of the partial vector.
- `in_valid` input 1: product beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `in_product` input `2*BIT_WIDTH`: unsigned product.
- `in_last` input 1: marks the final term of the vector.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid && out_ready`.
- `out_sum` output `ACC_WIDTH`: saturated vector sum.
- `out_count` output `CNT_WIDTH`: number of terms in the vector, saturating.
- `out_ovf` output 1: the sum saturated at some point in this vector.

## Operation

Internal state:

- Accumulator `acc`, term counter `cnt`, sticky overflow bit `ovf`.
- Output register holding `out_sum`, `out_count` and `out_ovf`, plus the `out_valid` bit.

Accumulate FSM:

- `EMPTY` (`cnt == 0`) moves to `PARTIAL` on a non-last accepted beat.
- `PARTIAL` returns to `EMPTY` on a last accepted beat or on `flush`.
- `EMPTY` with a last beat (a 1-term vector) stays in `EMPTY`.

Accepted beat arithmetic:

- `sum = acc + zero_ext(in_product)`, computed at `ACC_WIDTH+1` bits.
- If `sum` exceeds `2^ACC_WIDTH - 1`, clamp to all-ones and set overflow. Once `acc` is all-ones it stays there for the rest of the vector.
- `cnt` increments by 1, saturating at `2^CNT_WIDTH - 1`.

Non-last beat: `acc`, `cnt` and `ovf` take the new values.

Last beat:

- The output register loads the new sum, count and overflow.
- `out_valid` is set.
- `acc`, `cnt` and `ovf` clear to 0 in the same cycle.

Backpressure:

- `in_ready = !out_valid || out_ready`, a combinational function of registered `out_valid` and the `out_ready` input.
- The same rule applies to every beat, not only last beats, so there is no partial-acceptance corner.

Output handshake:

- `out_valid` clears on `out_valid && out_ready` unless a new last beat is accepted in the same cycle.
- If it is, the new result replaces the old one and `out_valid` stays 1, giving back-to-back results with no bubble.
- `out_sum`, `out_count` and `out_ovf` are stable while `out_valid && !out_ready`.

`flush`:

- Clears `acc`, `cnt` and `ovf`.
- Any beat presented in the same cycle is discarded, even if `in_valid && in_ready`.
- The output register and `out_valid` are unaffected. A pending result survives a flush.

Reset:

- Async assert sets `acc`, `cnt`, `ovf`, `out_sum`, `out_count` and `out_ovf` to 0 and `out_valid` to 0.
- `in_ready` therefore reads 1 during and after reset.
- Reset mid-vector drops the partial vector and any pending result.

## Timing

- A last beat accepted at edge N gives `out_valid = 1` with the result after edge N. Latency is 1 cycle from the accepting edge.
- Throughput is 1 beat/cycle, sustained indefinitely while `out_ready = 1` or no result is pending.
- Back-to-back vectors need no idle cycle between `in_last` and the next vector's first beat.
- With `out_valid = 1` and `out_ready = 0`, `in_ready = 0` and no beat is accepted, including non-last beats.
- No combinational path from `in_valid`/`in_product` to any output.
- Only path `out_ready` → `in_ready`.

## Test plan

- **Reset:** `rst_n = 1` mid-vector with a result pending → `out_valid = 0`, `out_sum = 0`, `in_ready = 1`; a new 2-term vector {3, 4} afterwards → `out_sum = 7`, `out_count = 2`.
- **Streaming:** vectors {1,2,3} and {10} back-to-back with `out_ready = 1` → results 6/count 3, then 10/count 1 on consecutive-or-adjacent cycles, with no dropped beats.
- **Backpressure:** `out_ready = 0` after a result of 6 → `in_ready = 0`, `out_sum` holds 6 for 5 cycles; release `out_ready` in the same cycle as a last beat → next result loads with no bubble.
- **Saturation:** `ACC_WIDTH = 16`, vector {0xFF00, 0x0200, 0x0001} → `out_sum = 0xFFFF`, `out_ovf = 1`; the next vector {5} → `out_sum = 5`, `out_ovf = 0`.
- **Flush:** flush while in `PARTIAL` after {7, 8}, with a beat of 9 presented in the same cycle → beat discarded; the following vector {2} → `out_sum = 2`, `out_count = 1`; a pending result across the flush is unchanged.
- **Random:** random valid/ready toggling against a reference model → every sum, count and overflow matches and `in_ready` follows its equation each cycle.
